// File: rtl/uart_key_rx.sv
// 8N1 serial receiver feeding the key converter.
// Mid-bit sampling, frame-error detection and break hold-off.
module uart_key_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] key,
  output logic       key_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic [7:0]    key_n;
  logic          kv_n, fe_n;
  logic          rx_m, rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      timer     <= '0;
      idx       <= '0;
      sh        <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      state     <= state_n;
      timer     <= timer_n;
      idx       <= idx_n;
      sh        <= sh_n;
      key       <= key_n;
      key_valid <= kv_n;
      frame_err <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer + TW'(1);
    idx_n   = idx;
    sh_n    = sh;
    key_n   = key;
    kv_n    = 1'b0;
    fe_n    = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (timer == HALF) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == LAST) begin
          timer_n  = '0;
          sh_n[idx] = rx_s;
          idx_n    = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (timer == LAST) begin
          timer_n = '0;
          if (rx_s) begin
            key_n   = sh;
            kv_n    = 1'b1;
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        // line held low after a bad stop bit: wait for idle
        timer_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_key_rx.sv
// Self-checking bench for uart_key_rx.
// Frames are generated from byte values; a monitor logs output pulses.
module tb_uart_key_rx;

  localparam int CPB = 16;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] key;
  logic       key_valid;
  logic       frame_err;
  logic       busy;

  int tests_run = 0;
  int fails = 0;

  logic [7:0] kv_q[$];
  int fe_cnt = 0;
  int both_cnt = 0;

  uart_key_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .key(key),
    .key_valid(key_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_q.push_back(key);
    if (frame_err === 1'b1) fe_cnt++;
    if (key_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (key !== 8'h00) begin
      fails++;
      $display("FAIL reset_key got=%h exp=00", key);
    end
    tests_run++;
    if (key_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_kv got=%b exp=0", key_valid);
    end
    tests_run++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_fe got=%b exp=0", frame_err);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    kv_q.delete();
    fe_cnt = 0;
    n = 0;
    fork
      send_frame(8'h70, 1'b1);
      begin
        while (key_valid !== 1'b1 && n < 300) begin
          @(negedge clk);
          n++;
        end
      end
    join
    tests_run++;
    if (n != LAT) begin
      fails++;
      $display("FAIL single_latency got=%0d exp=%0d", n, LAT);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (kv_q.size() != 1 || key !== 8'h70) begin
      fails++;
      $display("FAIL single_key got=%h pulses=%0d exp=70 pulses=1",
               key, kv_q.size());
    end
    tests_run++;
    if (busy !== 1'b0 || fe_cnt != 0) begin
      fails++;
      $display("FAIL single_idle busy=%b fe=%0d exp busy=0 fe=0",
               busy, fe_cnt);
    end
  endtask

  task automatic test_glitch();
    int n;
    kv_q.delete();
    fe_cnt = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL glitch_start busy=%b exp=1", busy);
    end
    rx = 1'b1;
    n = 0;
    while (busy === 1'b1 && n <= CPB / 2 + 3) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy got=%b after=%0d exp=0", busy, n);
    end
    repeat (2 * CPB) @(negedge clk);
    tests_run++;
    if (kv_q.size() != 0 || fe_cnt != 0 || key !== 8'h70) begin
      fails++;
      $display("FAIL glitch_out kv=%0d fe=%0d key=%h exp 0 0 70",
               kv_q.size(), fe_cnt, key);
    end
  endtask

  task automatic test_frame_err();
    kv_q.delete();
    fe_cnt = 0;
    send_frame(8'h01, 1'b1);
    send_frame(8'hA5, 1'b0);
    repeat (40) @(negedge clk);
    tests_run++;
    if (fe_cnt != 1 || kv_q.size() != 1) begin
      fails++;
      $display("FAIL ferr_pulses fe=%0d kv=%0d exp fe=1 kv=1",
               fe_cnt, kv_q.size());
    end
    tests_run++;
    if (key !== 8'h01) begin
      fails++;
      $display("FAIL ferr_key got=%h exp=01", key);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ferr_break_busy got=%b exp=1", busy);
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ferr_release_busy got=%b exp=0", busy);
    end
    repeat (2 * CPB) @(negedge clk);
    tests_run++;
    if (fe_cnt != 1 || kv_q.size() != 1) begin
      fails++;
      $display("FAIL ferr_quiet fe=%0d kv=%0d exp fe=1 kv=1",
               fe_cnt, kv_q.size());
    end
  endtask

  task automatic test_back_to_back();
    kv_q.delete();
    fe_cnt = 0;
    send_frame(8'h01, 1'b1);
    send_frame(8'h10, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (kv_q.size() != 2) begin
      fails++;
      $display("FAIL b2b_count got=%0d exp=2", kv_q.size());
    end else begin
      tests_run++;
      if (kv_q[0] !== 8'h01 || kv_q[1] !== 8'h10) begin
        fails++;
        $display("FAIL b2b_keys got=%h,%h exp=01,10", kv_q[0], kv_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    kv_q.delete();
    fe_cnt = 0;
    rx = 1'b0;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (key !== 8'h00 || key_valid !== 1'b0 ||
          frame_err !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL midrst_outs key=%h kv=%b fe=%b busy=%b exp all 0",
                 key, key_valid, frame_err, busy);
      end
    end
    rst_n = 1'b1;
    send_frame(8'h1F, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (kv_q.size() != 1 || key !== 8'h1F || fe_cnt != 0) begin
      fails++;
      $display("FAIL midrst_frame kv=%0d key=%h fe=%0d exp 1 1f 0",
               kv_q.size(), key, fe_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [7:0] last;
    logic       stop;
    int         fe_exp;
    kv_q.delete();
    fe_cnt = 0;
    both_cnt = 0;
    fe_exp = 0;
    last = 8'h1F;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      if (stop) begin
        exp_q.push_back(b);
        last = b;
      end else begin
        fe_exp++;
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (kv_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL rand_count got=%0d exp=%0d", kv_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (kv_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL rand_key[%0d] got=%h exp=%h", i, kv_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (fe_cnt != fe_exp) begin
      fails++;
      $display("FAIL rand_ferr got=%0d exp=%0d", fe_cnt, fe_exp);
    end
    tests_run++;
    if (key !== last) begin
      fails++;
      $display("FAIL rand_hold got=%h exp=%h", key, last);
    end
    tests_run++;
    if (both_cnt != 0) begin
      fails++;
      $display("FAIL rand_overlap got=%0d exp=0", both_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/uart_key_rx.md
UART_KEY_RX -- requirements
Module: uart_key_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416, clock cycles per serial bit (100 MHz / 9600 baud); legal minimum 4.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 rx  input  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-005 key  output  8  last correctly framed byte; drives the key input of the downstream key converter.
REQ-006 key_valid  output  1  one-cycle pulse when key is updated.
REQ-007 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s (2-cycle input latency).
REQ-010 States SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-011 IDLE: the block SHALL enter START on the first cycle rx_s==0, clearing the bit-timer.
REQ-012 START: at timer==CLKS_PER_BIT/2-1 (integer division), rx_s==0 SHALL go to DATA with timer cleared and bit index 0; rx_s==1 SHALL return to IDLE (glitch rejection) with no output pulse.
REQ-013 DATA: at each timer==CLKS_PER_BIT-1, rx_s SHALL be shifted into bit[index] (LSB first) and the timer cleared; after index 7 is sampled, go to STOP.
REQ-014 STOP: at timer==CLKS_PER_BIT-1, rx_s==1 SHALL load key with the shifted byte, pulse key_valid for exactly one cycle and return to IDLE.
REQ-015 STOP: at timer==CLKS_PER_BIT-1, rx_s==0 SHALL pulse frame_err for one cycle, leave key unchanged, suppress key_valid and enter BREAK.
REQ-016 BREAK: the block SHALL stay until rx_s==1, then go to IDLE; no new frame SHALL start while in BREAK.
REQ-017 key_valid and frame_err SHALL never be high in the same cycle; each pulse SHALL be exactly one cycle wide.
REQ-018 key SHALL hold its value between valid frames, including across frame errors and rejected starts.
REQ-019 The bit-timer SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap within a bit period.
REQ-020 Back-to-back frames (start bit directly after stop bit) SHALL be received: IDLE is re-entered one cycle after the stop sample, before the next start-bit midpoint.
REQ-021 busy SHALL be low in IDLE and high in START, DATA, STOP and BREAK.

Reset
REQ-022 With rst_n==0 at a rising edge: state=IDLE, timer=0, bit index=0, shift register=0x00, key=0x00, key_valid=0, frame_err=0, busy=0, both synchronizer flops=1.
REQ-023 Reset SHALL take priority over every transition, including mid-frame; a partially received byte SHALL be discarded with no pulse.
REQ-024 After rst_n returns high, the first frame SHALL be received normally, with no extra idle time.

Verification (CLKS_PER_BIT=16)
REQ-025 Send 0x70 with a valid stop bit -> key=0x70 and one key_valid pulse, 1 cycle after the stop-bit sample; busy then low.
REQ-026 Drive rx low for 4 cycles, then high -> no key_valid, no frame_err, key unchanged, busy back to 0 within CLKS_PER_BIT/2+3 cycles.
REQ-027 Send 0x01, then a frame whose stop bit is 0 and hold rx low for 40 cycles -> one frame_err pulse, key stays 0x01, busy stays high until rx returns high, no further pulses.
REQ-028 Send 0x01 and 0x10 back-to-back with no idle gap -> two key_valid pulses, key=0x01 then key=0x10.
REQ-029 Assert rst_n low during data bit 3 of 0x80, release, then send 0x1F -> all outputs 0 during reset, no pulse for the aborted frame, then key=0x1F with one key_valid.
